// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// requester IDs, the error response word and the access legality check.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [31:0] ERR_DATA = 32'h0;

    // An access is illegal if it is not word aligned or lies past the last word.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] max_addr);
        return (addr[1:0] != 2'b00) || (addr > max_addr);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Priority decision between fetch and data requesters, with a starvation
// counter that hands the port to fetch after pStarveLimit back-to-back data grants.
module mem_port_arbiter_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [7:0] pStarveLimit = 8'd4
) (
    input  logic iwClk,
    input  logic iwRst,
    input  logic iwIReq,
    input  logic iwDReq,
    input  logic iwIdle,
    input  logic iwGrant,
    output logic owWinner
);

    logic [7:0] starve_q, starve_d;

    always_comb begin
        owWinner = REQ_I;
        if (iwDReq && !(iwIReq && (starve_q == pStarveLimit))) begin
            owWinner = REQ_D;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        starve_d = starve_q;
        if (iwGrant && (owWinner == REQ_I)) begin
            starve_d = 8'd0;
        end else if (iwGrant && iwIReq) begin
            starve_d = starve_q + 8'd1;
        end else if (iwIdle && !iwIReq) begin
            starve_d = 8'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: accepts one request,
// spends one ACCESS cycle on the memory, then returns a registered response.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [31:0] pWords       = 32'd44,
    parameter logic [7:0]  pStarveLimit = 8'd4
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwIReq,
    input  logic [31:0] iwIAddr,
    output logic        owIAck,
    output logic        owIValid,
    output logic [31:0] owIData,
    output logic        owIErr,
    input  logic        iwDReq,
    input  logic [31:0] iwDAddr,
    input  logic [31:0] iwDWdata,
    input  logic [3:0]  iwDWstrb,
    output logic        owDAck,
    output logic        owDValid,
    output logic [31:0] owDRdata,
    output logic        owDErr,
    output logic [31:0] owMemReadAddr,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb,
    input  logic [31:0] iwMemReadData
);

    localparam logic [31:0] MAX_ADDR = (pWords << 2) - 32'd4;

    state_t      state_q, state_d;
    req_id_t     id_q, id_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        i_valid_q, i_valid_d, i_err_q, i_err_d;
    logic [31:0] i_data_q, i_data_d;
    logic        d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic [31:0] d_data_q, d_data_d;
    logic        winner;
    logic        idle;
    logic        grant;

    // Acks are combinational, so they must also be held off while reset is asserted.
    assign idle   = (state_q == IDLE) && !iwRst;
    assign owIAck = idle && iwIReq && (winner == REQ_I);
    assign owDAck = idle && iwDReq && (winner == REQ_D);
    assign grant  = owIAck || owDAck;

    mem_port_arbiter_prio #(
        .pStarveLimit (pStarveLimit)
    ) u_prio (
        .iwClk    (iwClk),
        .iwRst    (iwRst),
        .iwIReq   (iwIReq),
        .iwDReq   (iwDReq),
        .iwIdle   (idle),
        .iwGrant  (grant),
        .owWinner (winner)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        i_valid_d = 1'b0;
        i_data_d  = i_data_q;
        i_err_d   = i_err_q;
        d_valid_d = 1'b0;
        d_data_d  = d_data_q;
        d_err_d   = d_err_q;
        if (state_q == IDLE) begin
            if (grant) begin
                id_d    = owDAck ? REQ_D : REQ_I;
                addr_d  = owDAck ? iwDAddr : iwIAddr;
                wdata_d = owDAck ? iwDWdata : 32'h0;
                err_d   = addr_bad(addr_d, MAX_ADDR);
                // Illegal accesses still take the ACCESS cycle but never write.
                wstrb_d = (owDAck && !err_d) ? iwDWstrb : 4'h0;
                state_d = ACCESS;
            end
        end else begin
            state_d = IDLE;
            wstrb_d = 4'h0;
            if (id_q == REQ_D) begin
                d_valid_d = 1'b1;
                d_data_d  = err_q ? ERR_DATA : iwMemReadData;
                d_err_d   = err_q;
            end else begin
                i_valid_d = 1'b1;
                i_data_d  = err_q ? ERR_DATA : iwMemReadData;
                i_err_d   = err_q;
            end
        end
    end

    // NOTE: every register here is control or datapath state, so all are reset.
    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state_q   <= IDLE;
            id_q      <= REQ_I;
            err_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            i_valid_q <= 1'b0;
            i_data_q  <= 32'h0;
            i_err_q   <= 1'b0;
            d_valid_q <= 1'b0;
            d_data_q  <= 32'h0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            i_valid_q <= i_valid_d;
            i_data_q  <= i_data_d;
            i_err_q   <= i_err_d;
            d_valid_q <= d_valid_d;
            d_data_q  <= d_data_d;
            d_err_q   <= d_err_d;
        end
    end

    assign owIValid       = i_valid_q;
    assign owIData        = i_data_q;
    assign owIErr         = i_err_q;
    assign owDValid       = d_valid_q;
    assign owDRdata       = d_data_q;
    assign owDErr         = d_err_q;
    assign owMemReadAddr  = addr_q;
    assign owMemWriteAddr = addr_q;
    assign owMemWriteData = wdata_q;
    assign owMemWstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural negedge-write memory,
// a shadow memory model and per-requester response scoreboards.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int          WORDS    = 44;
    localparam logic [31:0] MAX_ADDR = 32'd172;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_ack, i_valid, i_err;
    logic [31:0] i_data;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic        d_ack, d_valid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem    [WORDS];
    logic [31:0] shadow [WORDS];
    resp_t       i_exp[$];
    resp_t       d_exp[$];
    logic        grant_log[$];
    int          grant_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          i_valid_cyc = -1;
    int          d_valid_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    mem_port_arbiter #(
        .pWords       (32'd44),
        .pStarveLimit (8'd2)
    ) dut (
        .iwClk          (clk),
        .iwRst          (rst),
        .iwIReq         (i_req),
        .iwIAddr        (i_addr),
        .owIAck         (i_ack),
        .owIValid       (i_valid),
        .owIData        (i_data),
        .owIErr         (i_err),
        .iwDReq         (d_req),
        .iwDAddr        (d_addr),
        .iwDWdata       (d_wdata),
        .iwDWstrb       (d_wstrb),
        .owDAck         (d_ack),
        .owDValid       (d_valid),
        .owDRdata       (d_rdata),
        .owDErr         (d_err),
        .owMemReadAddr  (mem_raddr),
        .owMemWriteAddr (mem_waddr),
        .owMemWriteData (mem_wdata),
        .owMemWstrb     (mem_wstrb),
        .iwMemReadData  (mem_rdata)
    );

    // Behavioural memory: combinational read, byte-lane write on negedge.
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_raddr <= MAX_ADDR) mem_rdata = mem[mem_raddr >> 2];
    end

    always @(negedge clk) begin
        if (mem_wstrb != 4'h0 && mem_waddr <= MAX_ADDR) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_waddr >> 2][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic model(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic is_d, output resp_t r);
        if (addr[1:0] != 2'b00 || addr > MAX_ADDR) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end else begin
            if (is_d) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) shadow[addr >> 2][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            r.data = shadow[addr >> 2];
            r.err  = 1'b0;
        end
    endtask

    // Scoreboard: push on accept, pop and compare on each valid pulse.
    always @(posedge clk) begin
        resp_t r;
        resp_t e;
        #2;
        checks++;
        if (i_ack && d_ack) begin
            errors++;
            $display("FAIL dual_ack: i_ack=%b d_ack=%b, required at most one", i_ack, d_ack);
        end
        if (!rst && i_req && i_ack) begin
            model(i_addr, 32'h0, 4'h0, 1'b0, r);
            i_exp.push_back(r);
            grant_log.push_back(1'b0);
            grant_cyc.push_back(cyc);
        end
        if (!rst && d_req && d_ack) begin
            model(d_addr, d_wdata, d_wstrb, 1'b1, r);
            d_exp.push_back(r);
            grant_log.push_back(1'b1);
            grant_cyc.push_back(cyc);
        end
        if (i_valid) begin
            i_valid_cyc = cyc;
            checks++;
            if (i_exp.size() == 0) begin
                errors++;
                $display("FAIL i_unexpected_valid: data=%h err=%b, no response pending", i_data, i_err);
            end else begin
                e = i_exp.pop_front();
                if ({i_data, i_err} !== {e.data, e.err}) begin
                    errors++;
                    $display("FAIL i_resp: got data=%h err=%b, required data=%h err=%b",
                             i_data, i_err, e.data, e.err);
                end
            end
        end
        if (d_valid) begin
            d_valid_cyc = cyc;
            checks++;
            if (d_exp.size() == 0) begin
                errors++;
                $display("FAIL d_unexpected_valid: data=%h err=%b, no response pending", d_rdata, d_err);
            end else begin
                e = d_exp.pop_front();
                if ({d_rdata, d_err} !== {e.data, e.err}) begin
                    errors++;
                    $display("FAIL d_resp: got data=%h err=%b, required data=%h err=%b",
                             d_rdata, d_err, e.data, e.err);
                end
            end
        end
    end

    // Raise one request, hold it until acked (bounded), drop it just after the accept edge.
    task automatic request(input logic is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int ack_cyc, output int lat);
        bit got = 1'b0;
        ack_cyc = -1;
        lat     = -1;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            #2;
            if (is_d ? d_ack : i_ack) begin
                got = 1'b1; ack_cyc = cyc; lat = n;
            end
            @(posedge clk); #1;
        end
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: is_d=%b addr=%h got no ack, required ack", is_d, addr);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((i_exp.size() != 0 || d_exp.size() != 0) && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        checks++;
        if (i_exp.size() != 0 || d_exp.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout: pending i=%0d d=%0d, required 0", i_exp.size(), d_exp.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_addr = 32'h4; d_wdata = 32'h55; d_wstrb = 4'hF;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #3;
            checks++;
            if ({i_ack, d_ack, i_valid, d_valid, i_err, d_err} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl: got %b, required 000000",
                         {i_ack, d_ack, i_valid, d_valid, i_err, d_err});
            end
            checks++;
            if ({i_data, d_rdata, mem_raddr, mem_waddr, mem_wdata} !== 160'b0) begin
                errors++;
                $display("FAIL reset_data: got %h %h %h %h %h, required all 0",
                         i_data, d_rdata, mem_raddr, mem_waddr, mem_wdata);
            end
            checks++;
            if (mem_wstrb !== 4'h0) begin
                errors++;
                $display("FAIL reset_wstrb: got %h, required 0", mem_wstrb);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        int k, lat;
        request(1'b0, 32'h8, 32'h0, 4'h0, k, lat);
        drain();
        checks++;
        if (i_valid_cyc !== k + 2) begin
            errors++;
            $display("FAIL fetch_latency: valid in cycle %0d, required %0d", i_valid_cyc, k + 2);
        end
        checks++;
        if ({i_data, i_err} !== {32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL fetch_data: got %h err=%b, required deadbeef err=0", i_data, i_err);
        end
    endtask

    task automatic test_data_write();
        int k, lat;
        request(1'b1, 32'h10, 32'h11223344, 4'hF, k, lat);
        #2;
        checks++;
        if (mem_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL write_wstrb_access: got %h, required f", mem_wstrb);
        end
        @(posedge clk); #3;
        checks++;
        if (mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL write_wstrb_after: got %h, required 0", mem_wstrb);
        end
        drain();
        checks++;
        if (mem[4] !== 32'h11223344) begin
            errors++;
            $display("FAIL write_mem: got %h, required 11223344", mem[4]);
        end
        request(1'b0, 32'h10, 32'h0, 4'h0, k, lat);
        drain();
        checks++;
        if (i_data !== 32'h11223344) begin
            errors++;
            $display("FAIL write_readback: got %h, required 11223344", i_data);
        end
    endtask

    task automatic test_contention();
        bit [5:0] exp_seq = 6'b011011;
        int n = 0;
        grant_log.delete();
        grant_cyc.delete();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'hC;
        d_req = 1'b1; d_addr = 32'h4; d_wdata = 32'h0; d_wstrb = 4'h0;
        while (grant_log.size() < 6 && n < 40) begin
            @(posedge clk); #3;
            n++;
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (grant_log.size() != 6) begin
            errors++;
            $display("FAIL contention_count: got %0d grants, required 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL contention_order[%0d]: got %s, required %s", i,
                             grant_log[i] ? "D" : "I", exp_seq[i] ? "D" : "I");
                end
            end
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (grant_cyc[i] - grant_cyc[i-1] != 2) begin
                    errors++;
                    $display("FAIL contention_gap[%0d]: got %0d cycles, required 2", i,
                             grant_cyc[i] - grant_cyc[i-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_errors();
        int k, lat;
        logic [31:0] saved;
        saved = mem[1];
        request(1'b1, 32'h6, 32'hCAFEF00D, 4'hF, k, lat);
        #2;
        checks++;
        if (mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL err_wstrb_d: got %h, required 0", mem_wstrb);
        end
        drain();
        checks++;
        if ({d_rdata, d_err} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL err_resp_d: got %h err=%b, required 0 err=1", d_rdata, d_err);
        end
        checks++;
        if (mem[1] !== saved) begin
            errors++;
            $display("FAIL err_mem_unchanged: got %h, required %h", mem[1], saved);
        end
        request(1'b0, 32'hB0, 32'h0, 4'h0, k, lat);
        #2;
        checks++;
        if (mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL err_wstrb_i: got %h, required 0", mem_wstrb);
        end
        drain();
        checks++;
        if (i_valid_cyc !== k + 2 || {i_data, i_err} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL err_resp_i: cycle %0d data %h err=%b, required cycle %0d data 0 err=1",
                     i_valid_cyc, i_data, i_err, k + 2);
        end
    endtask

    task automatic test_reset_in_access();
        int k, lat;
        request(1'b1, 32'h14, 32'hA5A55A5A, 4'hF, k, lat);
        rst = 1'b1;
        d_exp.delete();
        @(posedge clk); #3;
        checks++;
        if (d_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_access_valid: got %b, required 0", d_valid);
        end
        checks++;
        if (mem[5] !== 32'hA5A55A5A) begin
            errors++;
            $display("FAIL rst_access_mem: got %h, required a5a55a5a", mem[5]);
        end
        checks++;
        if (mem_wstrb !== 4'h0 || mem_waddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_access_outputs: wstrb %h addr %h, required 0 0", mem_wstrb, mem_waddr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        request(1'b0, 32'h14, 32'h0, 4'h0, k, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL rst_access_idle: ack after %0d cycles, required 0", lat);
        end
        drain();
        checks++;
        if (i_data !== 32'hA5A55A5A) begin
            errors++;
            $display("FAIL rst_access_readback: got %h, required a5a55a5a", i_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = 32'h1000_0000 + i;
            shadow[i] = 32'h1000_0000 + i;
        end
        mem[2] = 32'hDEADBEEF; shadow[2] = 32'hDEADBEEF;
        mem[4] = 32'h0;        shadow[4] = 32'h0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_contention();
        test_errors();
        test_reset_in_access();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
